// File: rtl/timer_display.sv
// Restart-button conditioner and two-digit multiplexed seven-segment driver for a
// countdown timer, with blanking blink while the game is over.
module timer_display #(
    parameter int unsigned DEBOUNCE_CYCLES = 10000,
    parameter int unsigned REFRESH_CYCLES  = 1000,
    parameter int unsigned BLINK_CYCLES    = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn_restart,
    input  logic [4:0] seconds,
    input  logic       game_over,
    output logic       o_restart_game,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low gfedcba pattern for one BCD digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pat;
        pat = SEG_BLANK;
        case (digit)
            4'd0: pat = 7'h40;
            4'd1: pat = 7'h79;
            4'd2: pat = 7'h24;
            4'd3: pat = 7'h30;
            4'd4: pat = 7'h19;
            4'd5: pat = 7'h12;
            4'd6: pat = 7'h02;
            4'd7: pat = 7'h78;
            4'd8: pat = 7'h00;
            4'd9: pat = 7'h10;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    logic            btn_sync1;
    logic            btn_sync2;
    logic            btn_db;
    logic            btn_db_d;
    logic [DB_W-1:0] db_cnt;

    // Two-flop synchronizer for the raw pushbutton.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync1 <= 1'b0;
            btn_sync2 <= 1'b0;
        end else begin
            btn_sync1 <= i_btn_restart;
            btn_sync2 <= btn_sync1;
        end
    end

    // Accept a level change only after it has been stable for DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_sync2 == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // One-cycle pulse on the debounced press edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_d       <= 1'b0;
            o_restart_game <= 1'b0;
        end else begin
            btn_db_d       <= btn_db;
            o_restart_game <= btn_db & ~btn_db_d;
        end
    end

    logic [3:0] tens_c;
    logic [3:0] ones_c;
    logic [3:0] tens;
    logic [3:0] ones;

    // Binary to two BCD digits by range compare; input never exceeds 31.
    always_comb begin
        tens_c = 4'd0;
        ones_c = 4'(seconds);
        if (seconds >= 5'd30) begin
            tens_c = 4'd3;
            ones_c = 4'(seconds - 5'd30);
        end else if (seconds >= 5'd20) begin
            tens_c = 4'd2;
            ones_c = 4'(seconds - 5'd20);
        end else if (seconds >= 5'd10) begin
            tens_c = 4'd1;
            ones_c = 4'(seconds - 5'd10);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else begin
            tens <= tens_c;
            ones <= ones_c;
        end
    end

    logic [REF_W-1:0] ref_cnt;
    logic [1:0]       digit_idx;

    // Digit scan: dwell REFRESH_CYCLES on each of four positions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt   <= '0;
            digit_idx <= 2'd0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    logic [BLK_W-1:0] blink_cnt;
    logic             phase_on;

    // Blink phase only advances while the game is over; otherwise parked on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (!game_over) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            phase_on  <= ~phase_on;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

    logic       display_on_c;
    logic [6:0] seg_c;
    logic [3:0] an_c;

    // Gating by game_over directly lets the display return one cycle after restart.
    always_comb begin
        display_on_c = ~game_over | phase_on;
        seg_c        = SEG_BLANK;
        an_c         = AN_OFF;
        if (display_on_c) begin
            case (digit_idx)
                2'd0: begin
                    an_c  = 4'b1110;
                    seg_c = seg_encode(ones);
                end
                2'd1: begin
                    an_c  = 4'b1101;
                    seg_c = seg_encode(tens);
                end
                default: begin
                    an_c  = AN_OFF;
                    seg_c = SEG_BLANK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= seg_c;
            an  <= an_c;
        end
    end

endmodule

// File: tb/tb_timer_display.sv
// Directed bench for timer_display: per-cycle reference model plus literal checkpoints.
module tb_timer_display;

    localparam int D = 4;
    localparam int R = 4;
    localparam int B = 8;

    logic       clk;
    logic       rst_n;
    logic       i_btn_restart;
    logic [4:0] seconds;
    logic       game_over;
    logic       o_restart_game;
    logic [6:0] seg;
    logic [3:0] an;

    timer_display #(
        .DEBOUNCE_CYCLES(D),
        .REFRESH_CYCLES (R),
        .BLINK_CYCLES   (B)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_btn_restart (i_btn_restart),
        .seconds       (seconds),
        .game_over     (game_over),
        .o_restart_game(o_restart_game),
        .seg           (seg),
        .an            (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    int n = 0;
    int pulse_count = 0;
    int last_pulse_edge = -1;

    logic [6:0] enc_tab [10];
    initial begin
        enc_tab[0] = 7'h40; enc_tab[1] = 7'h79; enc_tab[2] = 7'h24; enc_tab[3] = 7'h30;
        enc_tab[4] = 7'h19; enc_tab[5] = 7'h12; enc_tab[6] = 7'h02; enc_tab[7] = 7'h78;
        enc_tab[8] = 7'h00; enc_tab[9] = 7'h10;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t edge=%0d)", name, act, exp, $time, n);
        end
    endtask

    // Reference model: outputs after an edge follow from time since reset,
    // length of the game_over run, and the button history.
    int  go_run;
    int  prev_sec;
    int  m_run;
    int  idx;
    bit  m_s1, m_s2, m_db, m_db_d;
    bit  on;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_p;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                n = 0; go_run = 0; prev_sec = 0; m_run = 0;
                m_s1 = 0; m_s2 = 0; m_db = 0; m_db_d = 0;
                exp_an = 4'hF; exp_seg = 7'h7F; exp_p = 1'b0;
            end else begin
                n++;
                exp_p  = m_db & ~m_db_d;
                m_db_d = m_db;
                if (m_s2 != m_db) begin
                    m_run++;
                    if (m_run == D) begin
                        m_db  = m_s2;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_s2 = m_s1;
                m_s1 = i_btn_restart;

                on  = !game_over || (((go_run / B) % 2) == 0);
                idx = ((n - 1) / R) % 4;
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
                if (on && idx == 0) begin
                    exp_an  = 4'b1110;
                    exp_seg = enc_tab[prev_sec % 10];
                end else if (on && idx == 1) begin
                    exp_an  = 4'b1101;
                    exp_seg = enc_tab[prev_sec / 10];
                end
                go_run   = game_over ? go_run + 1 : 0;
                prev_sec = int'(seconds);
            end
            #1;
            chk("an", 32'(an), 32'(exp_an));
            chk("seg", 32'(seg), 32'(exp_seg));
            chk("restart_pulse", 32'(o_restart_game), 32'(exp_p));
            if (o_restart_game) begin
                pulse_count++;
                last_pulse_edge = n;
            end
        end
    end

    task automatic wait_edge(input int k);
        int guard;
        guard = 0;
        while (n < k && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (n < k) chk("wait_edge_timeout", 32'(n), 32'(k));
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == target) found = 1;
        end
        if (!found) chk(name, 32'(an), 32'(target));
    endtask

    int p0;
    int settle;

    initial begin
        rst_n = 1'b0; i_btn_restart = 1'b0; seconds = 5'd0; game_over = 1'b0;
        cycles(3);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_pulse", 32'(o_restart_game), 32'h0);

        // Button held through reset: single pulse at edge D+3.
        i_btn_restart = 1'b1;
        rst_n = 1'b1;
        wait_edge(10);
        chk("held_rst_pulse_edge", 32'(last_pulse_edge), 32'(D + 3));
        chk("held_rst_pulse_cnt", 32'(pulse_count), 32'd1);
        wait_edge(30);
        chk("held_rst_single", 32'(pulse_count), 32'd1);
        i_btn_restart = 1'b0;
        cycles(20);

        // "30" and "07".
        seconds = 5'd30;
        cycles(2);
        wait_an(4'b1110, "s30_ones_an");
        chk("s30_ones_seg", 32'(seg), 32'h40);
        wait_an(4'b1101, "s30_tens_an");
        chk("s30_tens_seg", 32'(seg), 32'h30);
        seconds = 5'd7;
        cycles(2);
        wait_an(4'b1110, "s07_ones_an");
        chk("s07_ones_seg", 32'(seg), 32'h78);
        wait_an(4'b1101, "s07_tens_an");
        chk("s07_tens_seg", 32'(seg), 32'h40);
        seconds = 5'd19;
        cycles(20);
        seconds = 5'd31;
        cycles(20);

        // Bouncy press, then settle high.
        p0 = pulse_count;
        i_btn_restart = 1'b1; cycles(1);
        i_btn_restart = 1'b0; cycles(1);
        i_btn_restart = 1'b1; cycles(2);
        i_btn_restart = 1'b0; cycles(1);
        i_btn_restart = 1'b1; cycles(3);
        i_btn_restart = 1'b0; cycles(1);
        i_btn_restart = 1'b1;
        settle = n;
        cycles(20);
        chk("bounce_one_pulse", 32'(pulse_count), 32'(p0 + 1));
        chk("bounce_pulse_edge", 32'(last_pulse_edge), 32'(settle + D + 3));
        i_btn_restart = 1'b0;
        cycles(20);
        chk("release_no_pulse", 32'(pulse_count), 32'(p0 + 1));

        // Long hold, release, re-press.
        p0 = pulse_count;
        i_btn_restart = 1'b1; cycles(100);
        chk("hold100_one_pulse", 32'(pulse_count), 32'(p0 + 1));
        i_btn_restart = 1'b0; cycles(20);
        i_btn_restart = 1'b1; cycles(20);
        chk("repress_pulse", 32'(pulse_count), 32'(p0 + 2));
        i_btn_restart = 1'b0; cycles(20);

        // Blink, aligned to a fresh reset so edge numbers are known.
        rst_n = 1'b0; seconds = 5'd0; game_over = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        wait_edge(2);
        game_over = 1'b1;
        wait_edge(5);
        chk("blink_on_an", 32'(an), 32'b1101);
        chk("blink_on_seg", 32'(seg), 32'h40);
        wait_edge(11);
        chk("blink_off_an", 32'(an), 32'hF);
        chk("blink_off_seg", 32'(seg), 32'h7F);
        wait_edge(17);
        chk("blink_off_idx0_an", 32'(an), 32'hF);
        game_over = 1'b0;
        wait_edge(18);
        chk("go_fall_an", 32'(an), 32'b1110);
        chk("go_fall_seg", 32'(seg), 32'h40);
        cycles(5);
        seconds = 5'd25;
        game_over = 1'b1;
        cycles(45);
        game_over = 1'b0;
        cycles(10);

        // Reset in the middle of a scan and a debounce.
        p0 = pulse_count;
        seconds = 5'd12;
        i_btn_restart = 1'b1;
        cycles(4);
        rst_n = 1'b0;
        #1;
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_pulse", 32'(o_restart_game), 32'h0);
        i_btn_restart = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        wait_edge(1);
        chk("resume_idx0_an", 32'(an), 32'b1110);
        chk("resume_idx0_seg", 32'(seg), 32'h40);
        wait_edge(2);
        chk("resume_ones_seg", 32'(seg), 32'h24);
        wait_edge(20);
        chk("midrst_no_pulse", 32'(pulse_count), 32'(p0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
